// File: rtl/icache_direct_if.sv
// Handshake bundle between the fetcher, the instruction cache and the
// memory controller's fetch port. "slave" is the cache side.
interface icache_direct_if;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_inst;

  modport slave (
    input  fetch_valid, fetch_addr, mem_ready, mem_inst,
    output fetch_ready, fetch_inst, mem_req, mem_addr
  );

  modport master (
    output fetch_valid, fetch_addr, mem_ready, mem_inst,
    input  fetch_ready, fetch_inst, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache (read-only toward memory).
// Define ICACHE_STAT_EN to build the hit_cnt/miss_cnt statistics counters.
module icache_direct #(
  parameter int INDEX_BITS = 6
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear,
  icache_direct_if.slave bus
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 16 - INDEX_BITS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MISS = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  fetch_ready_q, fetch_ready_d;
  logic [31:0]           fetch_inst_q, fetch_inst_d;
  logic                  mem_req_q, mem_req_d;
  logic [31:0]           mem_addr_q, mem_addr_d;
  logic [LINES-1:0]      valid_q, valid_d;

  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  req_hit;
  logic                  fill_we;
  logic                  hit_evt, miss_evt;
  logic                  unused_addr_bits;

  assign req_idx  = bus.fetch_addr[INDEX_BITS+1:2];
  assign req_tag  = bus.fetch_addr[17:INDEX_BITS+2];
  // The fill always targets the line of the outstanding miss address.
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[17:INDEX_BITS+2];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign unused_addr_bits = ^{bus.fetch_addr[31:18], bus.fetch_addr[1:0]};

  always_comb begin
    state_d       = state_q;
    fetch_ready_d = fetch_ready_q;
    fetch_inst_d  = fetch_inst_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    valid_d       = valid_q;
    fill_we       = 1'b0;
    hit_evt       = 1'b0;
    miss_evt      = 1'b0;

    if (rdy_in) begin
      if (clear) begin
        // Abandon any outstanding fetch; a coincident mem_ready is dropped.
        state_d       = S_IDLE;
        mem_req_d     = 1'b0;
        fetch_ready_d = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            fetch_ready_d = 1'b0;
            if (bus.fetch_valid) begin
              if (req_hit) begin
                fetch_inst_d  = data_q[req_idx];
                fetch_ready_d = 1'b1;
                state_d       = S_RESP;
                hit_evt       = 1'b1;
              end else begin
                mem_addr_d = {14'b0, bus.fetch_addr[17:2], 2'b00};
                mem_req_d  = 1'b1;
                state_d    = S_MISS;
                miss_evt   = 1'b1;
              end
            end
          end
          S_MISS: begin
            if (bus.mem_ready) begin
              fill_we           = 1'b1;
              valid_d[fill_idx] = 1'b1;
              fetch_inst_d      = bus.mem_inst;
              fetch_ready_d     = 1'b1;
              mem_req_d         = 1'b0;
              state_d           = S_RESP;
            end
          end
          S_RESP: begin
            fetch_ready_d = 1'b0;
            state_d       = S_IDLE;
          end
          default: begin
            fetch_ready_d = 1'b0;
            mem_req_d     = 1'b0;
            state_d       = S_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= S_IDLE;
      fetch_ready_q <= 1'b0;
      fetch_inst_q  <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      valid_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_ready_q <= fetch_ready_d;
      fetch_inst_q  <= fetch_inst_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      valid_q       <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_inst;
    end
  end

  assign bus.fetch_ready = fetch_ready_q;
  assign bus.fetch_inst  = fetch_inst_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Events are only raised while rdy_in is high, so stalls freeze counting.
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, hit_evt};
    miss_cnt_d = miss_cnt_q + {31'b0, miss_evt};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed vector table, multi-cycle
// clear/stall/reset sequences and randomized fetches against a line-map model.
module tb_icache_direct;
  localparam int IB    = 6;
  localparam int LINES = 1 << IB;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic clear;

  icache_direct_if bus();

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_direct #(.INDEX_BITS(IB)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .bus    (bus)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which word address each line currently holds, plus memory image.
  int unsigned ref_line [int unsigned];
  logic [31:0] mem_img  [int unsigned];
  int unsigned ref_hits   = 0;
  int unsigned ref_misses = 0;

  typedef struct {
    logic [31:0] addr;
    int          lat;
    bit          miss;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input int unsigned wa);
    if (!mem_img.exists(wa)) mem_img[wa] = $urandom;
    return mem_img[wa];
  endfunction

  function automatic bit ref_hit(input int unsigned wa);
    return ref_line.exists(wa % LINES) && (ref_line[wa % LINES] == wa);
  endfunction

  function automatic void ref_fill(input int unsigned wa);
    ref_line[wa % LINES] = wa;
  endfunction

  task automatic chk_counters(input string name);
`ifdef ICACHE_STAT_EN
    chk({name, " hit_cnt"}, hit_cnt, ref_hits);
    chk({name, " miss_cnt"}, miss_cnt, ref_misses);
`endif
  endtask

  // One complete fetch: acts as fetcher and as memory controller (reply after lat cycles).
  task automatic do_fetch(input string name, input logic [31:0] addr, input int lat,
                          input bit exp_miss, input logic [31:0] exp_inst);
    int unsigned wa;
    int          waited;
    bit          missed, served, done;
    wa     = (addr >> 2) & 32'h0000_FFFF;
    waited = 0;
    missed = 1'b0;
    served = 1'b0;
    done   = 1'b0;
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = addr;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      step();
      bus.mem_ready = 1'b0;
      if (bus.fetch_ready) begin
        done = 1'b1;
        bus.fetch_valid = 1'b0;
        chk({name, " latency"}, cyc, exp_miss ? 2 + lat : 1);
        chk({name, " inst"}, bus.fetch_inst, exp_inst);
      end else if (bus.mem_req && !served) begin
        missed = 1'b1;
        if (waited == lat) begin
          chk({name, " mem_addr"}, bus.mem_addr, wa << 2);
          bus.mem_ready = 1'b1;
          bus.mem_inst  = mem_word(wa);
          served = 1'b1;
        end
        waited++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: fetch_ready never seen in 40 cycles, expected a pulse", name);
      bus.fetch_valid = 1'b0;
    end
    chk({name, " miss"}, 32'(missed), 32'(exp_miss));
    step();
    bus.mem_ready = 1'b0;
    chk({name, " ready_pulse"}, bus.fetch_ready, 32'd0);
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear  = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_addr  = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_inst    = '0;

    mem_img[32'h400]  = 32'h0013_0093;
    mem_img[32'h8400] = 32'h3333_8400;
    mem_img[32'h40]   = 32'h1111_0040;
    mem_img[32'h80]   = 32'h2222_0080;
    mem_img[32'h401]  = 32'h4444_0401;

    vecs[0]  = '{32'h0000_1000, 3, 1'b1, 32'h0013_0093};  // cold miss
    vecs[1]  = '{32'h0000_1000, 0, 1'b0, 32'h0013_0093};  // refetch hits
    vecs[2]  = '{32'hFFFC_1003, 0, 1'b0, 32'h0013_0093};  // bits 31:18 and 1:0 ignored
    vecs[3]  = '{32'h0002_1000, 1, 1'b1, 32'h3333_8400};  // bit 17 is tag
    vecs[4]  = '{32'h0000_1000, 2, 1'b1, 32'h0013_0093};  // evicted by previous
    vecs[5]  = '{32'h0000_0100, 0, 1'b1, 32'h1111_0040};
    vecs[6]  = '{32'h0000_0200, 2, 1'b1, 32'h2222_0080};  // same index, new tag
    vecs[7]  = '{32'h0000_0100, 1, 1'b1, 32'h1111_0040};  // conflict miss again
    vecs[8]  = '{32'h0000_0102, 0, 1'b0, 32'h1111_0040};
    vecs[9]  = '{32'h0000_1004, 0, 1'b1, 32'h4444_0401};
    vecs[10] = '{32'h0004_1004, 0, 1'b0, 32'h4444_0401};

    #3 rst_in = 1'b0;
    #9;
    chk("reset fetch_ready", bus.fetch_ready, 32'd0);
    chk("reset fetch_inst", bus.fetch_inst, 32'd0);
    chk("reset mem_req", bus.mem_req, 32'd0);
    chk("reset mem_addr", bus.mem_addr, 32'd0);
    chk_counters("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    step();

    foreach (vecs[i]) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].miss, vecs[i].inst);
      if (vecs[i].miss) begin
        ref_misses++;
        ref_fill((vecs[i].addr >> 2) & 32'h0000_FFFF);
      end else begin
        ref_hits++;
      end
    end
    chk_counters("table");

    // clear one cycle before mem_ready: miss abandoned, line stays unfilled
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_2000;
    step();
    chk("clr_miss mem_req", bus.mem_req, 32'd1);
    chk("clr_miss mem_addr", bus.mem_addr, 32'h0000_2000);
    ref_misses++;
    step();
    chk("clr_miss req_held", bus.mem_req, 32'd1);
    clear = 1'b1;
    bus.fetch_valid = 1'b0;
    step();
    clear = 1'b0;
    chk("clr_miss req_drop", bus.mem_req, 32'd0);
    chk("clr_miss no_ready", bus.fetch_ready, 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_inst  = 32'hDEAD_0000;
    step();
    bus.mem_ready = 1'b0;
    chk("clr_miss late_reply", bus.fetch_ready, 32'd0);
    step();
    chk("clr_miss idle", bus.fetch_ready, 32'd0);
    do_fetch("clr_miss refetch", 32'h0000_2000, 1, 1'b1, mem_word(32'h800));
    ref_misses++;
    ref_fill(32'h800);

    // clear coincident with mem_ready: reply discarded
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_3000;
    step();
    chk("clr_rdy mem_req", bus.mem_req, 32'd1);
    ref_misses++;
    clear = 1'b1;
    bus.fetch_valid = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_inst  = mem_word(32'hC00);
    step();
    clear = 1'b0;
    bus.mem_ready = 1'b0;
    chk("clr_rdy req_drop", bus.mem_req, 32'd0);
    chk("clr_rdy no_ready", bus.fetch_ready, 32'd0);
    step();
    chk("clr_rdy idle", bus.fetch_ready, 32'd0);
    do_fetch("clr_rdy refetch", 32'h0000_3000, 0, 1'b1, mem_word(32'hC00));
    ref_misses++;
    ref_fill(32'hC00);
    chk_counters("clear");

    // rdy_in low for 5 cycles while the hit response is showing
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0000_3000;
    step();
    chk("stall hit_ready", bus.fetch_ready, 32'd1);
    ref_hits++;
    rdy_in = 1'b0;
    bus.fetch_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall hold%0d ready", k), bus.fetch_ready, 32'd1);
      chk($sformatf("stall hold%0d inst", k), bus.fetch_inst, mem_word(32'hC00));
    end
    rdy_in = 1'b1;
    step();
    chk("stall release", bus.fetch_ready, 32'd0);
    step();
    chk("stall no_dup", bus.fetch_ready, 32'd0);
    chk_counters("stall");

    // randomized fetches over a few conflicting tags on a handful of lines
    for (int i = 0; i < 120; i++) begin
      int unsigned wa;
      logic [31:0] addr;
      bit h;
      wa   = ($urandom_range(0, 2) << IB) | $urandom_range(0, 5);
      addr = ($urandom & 32'hFFFC_0003) | (wa << 2);
      h    = ref_hit(wa);
      do_fetch($sformatf("rand%0d", i), addr, $urandom_range(0, 4), !h, mem_word(wa));
      if (h) ref_hits++;
      else begin
        ref_misses++;
        ref_fill(wa);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    chk_counters("random");

    // make 0x3000 resident, then reset in the middle of a miss
    do_fetch("pre_rst fill", 32'h0000_3000, 0, !ref_hit(32'hC00), mem_word(32'hC00));
    bus.fetch_valid = 1'b1;
    bus.fetch_addr  = 32'h0001_5000;
    step();
    chk("rst_miss mem_req", bus.mem_req, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("rst_miss req_now", bus.mem_req, 32'd0);
    chk("rst_miss mem_addr", bus.mem_addr, 32'd0);
    chk("rst_miss fetch_inst", bus.fetch_inst, 32'd0);
    ref_line.delete();
    ref_hits   = 0;
    ref_misses = 0;
    chk_counters("rst_miss");
    bus.fetch_valid = 1'b0;
    step();
    rst_in = 1'b1;
    step();
    do_fetch("post_rst refetch", 32'h0000_3000, 0, 1'b1, mem_word(32'hC00));
    ref_misses++;
    chk_counters("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
